// File: rtl/module_buttons_switches_pkg.sv
// Shared constants for the button/switch input peripheral: register map
// addresses and the default debounce window.
package pkg_io_buttons;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

  localparam logic [1:0] ADDR_SW        = 2'd0;
  localparam logic [1:0] ADDR_BTN_LEVEL = 2'd1;
  localparam logic [1:0] ADDR_BTN_PEND  = 2'd2;
  localparam logic [1:0] ADDR_IRQ_MASK  = 2'd3;

endpackage

// File: rtl/module_buttons_switches_debouncer.sv
// Single-bit input conditioner: two-flop synchronizer followed by a
// counter that accepts a new level only after it has held long enough.
import pkg_io_buttons::*;

module module_debouncer #(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_count;

  // Any cycle where the synchronized pin agrees with the accepted level
  // restarts the count, so only an unbroken run can change the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_count  <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_count <= '0;
      end else if (r_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_count  <= '0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/module_buttons_switches.sv
// Memory-mapped read peripheral for board switches and push-buttons with
// sticky button-press flags and a maskable level interrupt.
import pkg_io_buttons::*;

module module_buttons_switches #(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 16,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_SW-1:0]  sw_in,
  input  logic [1:0]       addr,
  input  logic             re_io,
  input  logic             we_io,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  logic [N_BTN-1:0] w_stableBtn;
  logic [N_SW-1:0]  w_stableSw;
  logic [N_BTN-1:0] r_btnPrev;
  logic [N_BTN-1:0] w_btnRise;
  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] r_mask;
  logic [N_BTN-1:0] w_pendClr;
  logic             w_readPend;
  logic             w_writePend;
  logic             w_writeMask;
  logic             w_unusedWdata;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    module_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_pin    (btn_in[i]),
      .o_stable (w_stableBtn[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    module_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_pin    (sw_in[i]),
      .o_stable (w_stableSw[i])
    );
  end

  assign w_btnRise     = w_stableBtn & ~r_btnPrev;
  assign w_readPend    = re_io && (addr == ADDR_BTN_PEND);
  assign w_writePend   = we_io && (addr == ADDR_BTN_PEND);
  assign w_writeMask   = we_io && (addr == ADDR_IRQ_MASK);
  assign w_unusedWdata = ^wdata;

  always_comb begin
    w_pendClr = '0;
    if (w_readPend)  w_pendClr = '1;
    if (w_writePend) w_pendClr = w_pendClr | wdata[N_BTN-1:0];
  end

  // New rises are OR-ed in after the clear so a press is never lost to a
  // read or W1C that lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btnPrev <= '0;
      r_pend    <= '0;
      r_mask    <= '0;
    end else begin
      r_btnPrev <= w_stableBtn;
      r_pend    <= (r_pend & ~w_pendClr) | w_btnRise;
      if (w_writeMask) r_mask <= wdata[N_BTN-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (re_io) begin
      case (addr)
        ADDR_SW:        rdata = 32'(w_stableSw);
        ADDR_BTN_LEVEL: rdata = 32'(w_stableBtn);
        ADDR_BTN_PEND:  rdata = 32'(r_pend);
        ADDR_IRQ_MASK:  rdata = 32'(r_mask);
        default:        rdata = '0;
      endcase
    end
  end

  assign irq = |(r_pend & r_mask);

endmodule
